// File: rtl/pc_updater.sv
// Program counter and next-PC logic for the fetch stage: sequential +PC_INC or conditional
// PC-relative branch. Define PC_UPDATER_ALIGN_EN to force bit 0 of the next PC to zero.
`timescale 1ns/1ps
module pc_updater #(
  parameter int unsigned     WIDTH      = 16,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0,
  parameter int unsigned     PC_INC     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] InAddr,
  input  logic             branch,
  input  logic [2:0]       cond,
  input  logic             Z,
  input  logic             N,
  input  logic             V,
  output logic [WIDTH-1:0] OutAddr
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_seq;
  logic [WIDTH-1:0] w_tgt;
  logic [WIDTH-1:0] w_next_raw;
  logic [WIDTH-1:0] w_next;
  logic             w_cond_true;
  logic             w_taken;

  always_comb begin
    w_cond_true = 1'b0;
    case (cond)
      3'b000:  w_cond_true = ~Z;
      3'b001:  w_cond_true = Z;
      3'b010:  w_cond_true = ~Z & ~N;
      3'b011:  w_cond_true = N;
      3'b100:  w_cond_true = Z | ~N;
      3'b101:  w_cond_true = N | Z;
      3'b110:  w_cond_true = V;
      3'b111:  w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  // branch gates the decode so unknown flags cannot leak into the PC when not branching
  assign w_taken    = branch & w_cond_true;
  assign w_seq      = r_pc + WIDTH'(PC_INC);
  assign w_tgt      = w_seq + InAddr;
  assign w_next_raw = w_taken ? w_tgt : w_seq;

`ifdef PC_UPDATER_ALIGN_EN
  assign w_next = {w_next_raw[WIDTH-1:1], 1'b0};
`else
  assign w_next = w_next_raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_ADDR;
    end else begin
      r_pc <= w_next;
    end
  end

  assign OutAddr = r_pc;

endmodule

// File: tb/tb_pc_updater.sv
// Self-checking bench for pc_updater: vector table of condition codes plus hand-written
// sequences for reset, wrap, reset-over-branch and alignment.
`timescale 1ns/1ps
module tb_pc_updater;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] InAddr;
  logic        branch;
  logic [2:0]  cond;
  logic        Z, N, V;
  logic [15:0] OutAddr;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  logic [15:0] exp_q[$];

  pc_updater dut (
    .clk     (clk),
    .rst     (rst),
    .InAddr  (InAddr),
    .branch  (branch),
    .cond    (cond),
    .Z       (Z),
    .N       (N),
    .V       (V),
    .OutAddr (OutAddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cond;
    logic        z, n, v;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[32];

  // Reference condition table, written out directly from the condition-code list.
  function automatic logic ref_taken(input logic [2:0] c, input logic z, input logic n,
                                     input logic v);
    logic [7:0] t;
    t[0] = !z;
    t[1] = z;
    t[2] = !z && !n;
    t[3] = n;
    t[4] = z || !n;
    t[5] = n || z;
    t[6] = v;
    t[7] = 1'b1;
    return t[c];
  endfunction

  task automatic step(input logic r, input logic br, input logic [2:0] c, input logic z,
                      input logic n, input logic v, input logic [15:0] ia,
                      input logic [15:0] exp, input string name);
    logic [15:0] e;
    rst = r; branch = br; cond = c; Z = z; N = n; V = v; InAddr = ia;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL %s: scoreboard empty, OutAddr=%h", name, OutAddr);
    end else begin
      e = exp_q.pop_front();
      if (OutAddr !== e) begin
        n_miss++;
        $display("FAIL %s: OutAddr=%h expected=%h", name, OutAddr, e);
      end
    end
  endtask

  // Reset to 0x0000, then an unconditional branch lands on the even target.
  task automatic set_pc(input logic [15:0] target);
    step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, "setpc_rst");
    step(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, target - 16'h0002, target, "setpc_jmp");
  endtask

  initial begin
    logic [3:0] flags [4];
    flags[0] = 4'b0000; flags[1] = 4'b0100; flags[2] = 4'b0010; flags[3] = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 4; f++) begin
        vecs[c*4+f].cond = 3'(c);
        vecs[c*4+f].z    = flags[f][2];
        vecs[c*4+f].n    = flags[f][1];
        vecs[c*4+f].v    = flags[f][0];
        vecs[c*4+f].exp  = ref_taken(3'(c), flags[f][2], flags[f][1], flags[f][0])
                           ? 16'h00F2 : 16'h0102;
      end
    end

    rst = 1'b1; branch = 1'b0; cond = '0; Z = 0; N = 0; V = 0; InAddr = '0;
    @(posedge clk);
    #1;

    // Reset then sequential fetch
    step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, "reset");
    step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, "seq1");
    step(1'b0, 1'b0, 3'b111, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h0004, "seq2_nobranch");

    // NE branch from 0x0002, taken and not taken
    step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, "ne_rst");
    step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, "ne_seq");
    step(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0014, "ne_taken");
    step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, "ne_rst2");
    step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, "ne_seq2");
    step(1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0004, "ne_nottaken");

    // All condition codes against four flag sets at PC=0x0100, offset -16
    for (int i = 0; i < 32; i++) begin
      set_pc(16'h0100);
      step(1'b0, 1'b1, vecs[i].cond, vecs[i].z, vecs[i].n, vecs[i].v, 16'hFFF0,
           vecs[i].exp, $sformatf("cond%0d_zn v=%b%b%b", vecs[i].cond, vecs[i].z,
                                  vecs[i].n, vecs[i].v));
    end

    // Unknown condition/flags with branch=0 must fall through to sequential fetch
    set_pc(16'h0200);
    step(1'b0, 1'b0, 3'bxxx, 1'bx, 1'bx, 1'bx, 16'hxxxx, 16'h0202, "x_nobranch");

    // Wrap-around in both directions
    set_pc(16'hFFFE);
    step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, "wrap_seq");
    step(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 16'hFFFC, 16'hFFFE, "wrap_branch");

    // Reset wins over a taken unconditional branch
    set_pc(16'h0100);
    step(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, "rst_over_branch");
    step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, "after_rst");

    // Odd offset
    step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, "align_rst");
`ifdef PC_UPDATER_ALIGN_EN
    step(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0006, "align_odd");
`else
    step(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0007, "align_odd");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
